pc_branch_unit: RTL and testbench

// - Program-counter owner for the multi-cycle MIPS core; consumes the word-aligned, shifted branch offset (ImmExt<<2).
// - FETCH: PC <= PC+4. DECODE: target register BrTarget <= PC + Shiftby2 (PC already incremented).
// - EXECUTE: resolves beq/bne from ALU Zero, or j from the 26-bit jump field; redirects PC.
// - Counts taken branches and flags sequencing errors for the control FSM and debug.

---
 rtl/pc_branch_unit_pkg.sv | 21 ++
 rtl/pc_branch_unit_jump_calc.sv | 24 ++
 rtl/pc_branch_unit.sv | 98 +++++++++
 tb/tb_pc_branch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// Shared definitions for the PC/branch unit: FSM encoding, next-PC select
// codes and the fixed PC arithmetic constants.
package pc_branch_unit_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_INC    = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } pc_sel_t;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [1:0]  JUMP_ALIGN       = 2'b00;

endpackage

// File: rtl/pc_branch_unit_jump_calc.sv
// Combinational next-PC mux: hold, sequential increment, branch target or
// region-relative jump address.
module pc_jump_calc
    import pc_branch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] br_target,
    input  logic [25:0] jump_idx,
    input  pc_sel_t     sel,
    output logic [31:0] next_pc
);

    always_comb begin
        next_pc = pc;
        case (sel)
            SEL_INC:    next_pc = pc + PC_INC;
            SEL_BRANCH: next_pc = br_target;
            // j keeps the current 256 MB region of the PC
            SEL_JUMP:   next_pc = {pc[31:28], jump_idx, JUMP_ALIGN};
            default:    next_pc = pc;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program-counter owner for the multi-cycle core: holds PC and the decoded
// branch target, resolves beq/bne/j, counts redirects, flags sequencing errors.
//   state    | meaning
//   ST_IDLE  | no branch target held for the current instruction
//   ST_ARMED | BrTarget holds a target computed in decode
module pc_branch_unit
    import pc_branch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FetchEn,
    input  logic             TargetLoad,
    input  logic [31:0]      Shiftby2,
    input  logic             BranchEval,
    input  logic             BranchNe,
    input  logic             Zero,
    input  logic             JumpEn,
    input  logic [25:0]      JumpIdx,
    output logic [31:0]      PC,
    output logic [31:0]      BrTarget,
    output logic             TargetValid,
    output logic             BranchTaken,
    output logic [CNT_W-1:0] TakenCount,
    output logic             SeqError
);

    state_t      state, state_next;
    pc_sel_t     pc_sel;
    logic [31:0] next_pc;
    logic        load_target;
    logic        taken;
    logic        seq_err_set;

    pc_jump_calc u_jump_calc (
        .pc        (PC),
        .br_target (BrTarget),
        .jump_idx  (JumpIdx),
        .sel       (pc_sel),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Strobe priority: JumpEn > BranchEval > FetchEn > TargetLoad; losers are dropped.
    always_comb begin
        state_next  = state;
        pc_sel      = SEL_HOLD;
        load_target = 1'b0;
        taken       = 1'b0;
        seq_err_set = 1'b0;
        if (JumpEn) begin
            pc_sel     = SEL_JUMP;
            taken      = 1'b1;
            state_next = ST_IDLE;
        end else if (BranchEval) begin
            state_next = ST_IDLE;
            if (state == ST_ARMED) begin
                if (BranchNe ^ Zero) begin
                    pc_sel = SEL_BRANCH;
                    taken  = 1'b1;
                end
            end else begin
                seq_err_set = 1'b1;
            end
        end else if (FetchEn) begin
            pc_sel     = SEL_INC;
            state_next = ST_IDLE;
        end else if (TargetLoad) begin
            load_target = 1'b1;
            state_next  = ST_ARMED;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC          <= RESET_PC;
            BrTarget    <= 32'd0;
            BranchTaken <= 1'b0;
            TakenCount  <= '0;
            SeqError    <= 1'b0;
        end else begin
            PC          <= next_pc;
            BranchTaken <= taken;
            if (load_target) BrTarget <= PC + Shiftby2;
            if (taken)       TakenCount <= TakenCount + CNT_W'(1);
            if (seq_err_set) SeqError <= 1'b1;
        end
    end

    assign TargetValid = (state == ST_ARMED);

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed and randomized checks of pc_branch_unit against an instruction-level
// model of the PC, branch target, redirect counter and sequencing-error flag.
module tb_pc_branch_unit;

    localparam int TB_CNT_W = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic                FetchEn, TargetLoad, BranchEval, BranchNe, Zero, JumpEn;
    logic [31:0]         Shiftby2;
    logic [25:0]         JumpIdx;
    logic [31:0]         PC, BrTarget;
    logic                TargetValid, BranchTaken, SeqError;
    logic [TB_CNT_W-1:0] TakenCount;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    logic [31:0] m_pc, m_tgt, m_cnt;
    logic        m_valid, m_err, m_taken;

    pc_branch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .FetchEn     (FetchEn),
        .TargetLoad  (TargetLoad),
        .Shiftby2    (Shiftby2),
        .BranchEval  (BranchEval),
        .BranchNe    (BranchNe),
        .Zero        (Zero),
        .JumpEn      (JumpEn),
        .JumpIdx     (JumpIdx),
        .PC          (PC),
        .BrTarget    (BrTarget),
        .TargetValid (TargetValid),
        .BranchTaken (BranchTaken),
        .TakenCount  (TakenCount),
        .SeqError    (SeqError)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [TB_CNT_W-1:0] exp_cnt;
        exp_cnt = m_cnt[TB_CNT_W-1:0];
        chk({tag, ".PC"},          PC,                 m_pc);
        chk({tag, ".BrTarget"},    BrTarget,           m_tgt);
        chk({tag, ".TargetValid"}, 32'(TargetValid),   32'(m_valid));
        chk({tag, ".BranchTaken"}, 32'(BranchTaken),   32'(m_taken));
        chk({tag, ".TakenCount"},  32'(TakenCount),    32'(exp_cnt));
        chk({tag, ".SeqError"},    32'(SeqError),      32'(m_err));
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_tgt = 32'h0; m_cnt = 32'h0;
        m_valid = 1'b0; m_err = 1'b0; m_taken = 1'b0;
    endtask

    // One instruction-level step: the highest-priority strobe alone acts.
    task automatic model_step();
        m_taken = 1'b0;
        if (JumpEn) begin
            m_pc    = {m_pc[31:28], JumpIdx, 2'b00};
            m_taken = 1'b1;
            m_cnt   = m_cnt + 1;
            m_valid = 1'b0;
        end else if (BranchEval) begin
            if (!m_valid) m_err = 1'b1;
            else if ((Zero && !BranchNe) || (!Zero && BranchNe)) begin
                m_pc    = m_tgt;
                m_taken = 1'b1;
                m_cnt   = m_cnt + 1;
            end
            m_valid = 1'b0;
        end else if (FetchEn) begin
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b0;
        end else if (TargetLoad) begin
            m_tgt   = m_pc + Shiftby2;
            m_valid = 1'b1;
        end
    endtask

    task automatic clear_strobes();
        FetchEn = 0; TargetLoad = 0; BranchEval = 0; BranchNe = 0; Zero = 0; JumpEn = 0;
        Shiftby2 = 32'h0; JumpIdx = 26'h0;
    endtask

    task automatic step(input string tag, input logic fe, input logic tl, input logic be,
                        input logic bne, input logic z, input logic je,
                        input logic [31:0] sh, input logic [25:0] ji);
        FetchEn = fe; TargetLoad = tl; BranchEval = be; BranchNe = bne; Zero = z;
        JumpEn = je; Shiftby2 = sh; JumpIdx = ji;
        @(posedge clk); #1;
        model_step();
        check_all(tag);
        clear_strobes();
    endtask

    task automatic do_reset(input string tag, input bit with_strobes);
        reset = 1'b1;
        if (with_strobes) begin
            FetchEn = 1; TargetLoad = 1; BranchEval = 1; JumpEn = 1;
            Shiftby2 = 32'h40; JumpIdx = 26'h3FF_FFFF;
        end
        #2;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk); #1;
        check_all({tag, ".held"});
        reset = 1'b0;
        clear_strobes();
    endtask

    task automatic fetch_n(input int n);
        for (int i = 0; i < n; i++) step("fetch", 1, 0, 0, 0, 0, 0, 32'h0, 26'h0);
    endtask

    initial begin
        logic [31:0] r;
        int          k;
        clear_strobes();
        reset = 1'b1;
        model_reset();
        #3;
        check_all("por");
        chk("por.PC_lit", PC, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // sequential fetch
        step("f1", 1, 0, 0, 0, 0, 0, 32'h0, 26'h0); chk("f1.lit", PC, 32'h4);
        step("f2", 1, 0, 0, 0, 0, 0, 32'h0, 26'h0); chk("f2.lit", PC, 32'h8);
        step("f3", 1, 0, 0, 0, 0, 0, 32'h0, 26'h0); chk("f3.lit", PC, 32'hC);
        chk("f3.valid_lit", 32'(TargetValid), 32'h0);
        chk("f3.cnt_lit", 32'(TakenCount), 32'h0);

        // taken beq from 0x100
        do_reset("r1", 0);
        fetch_n(64);
        chk("beq.start_lit", PC, 32'h100);
        step("beq.load", 0, 1, 0, 0, 0, 0, 32'h20, 26'h0);
        chk("beq.tgt_lit", BrTarget, 32'h120);
        chk("beq.valid_lit", 32'(TargetValid), 32'h1);
        step("beq.eval", 0, 0, 1, 0, 1, 0, 32'h0, 26'h0);
        chk("beq.pc_lit", PC, 32'h120);
        chk("beq.pulse_lit", 32'(BranchTaken), 32'h1);
        chk("beq.cnt_lit", 32'(TakenCount), 32'h1);
        step("beq.after", 0, 0, 0, 0, 0, 0, 32'h0, 26'h0);
        chk("beq.pulse_end_lit", 32'(BranchTaken), 32'h0);

        // not-taken bne with negative offset
        do_reset("r2", 0);
        fetch_n(64);
        step("bne.load", 0, 1, 0, 0, 0, 0, 32'hFFFF_FFF0, 26'h0);
        chk("bne.tgt_lit", BrTarget, 32'hF0);
        step("bne.eval", 0, 0, 1, 1, 1, 0, 32'h0, 26'h0);
        chk("bne.pc_lit", PC, 32'h100);
        chk("bne.pulse_lit", 32'(BranchTaken), 32'h0);
        chk("bne.valid_lit", 32'(TargetValid), 32'h0);

        // jump beats a same-cycle BranchEval (which would otherwise set SeqError)
        do_reset("r3", 0);
        step("j.load", 0, 1, 0, 0, 0, 0, 32'h4000_0010, 26'h0);
        step("j.br", 0, 0, 1, 0, 1, 0, 32'h0, 26'h0);
        chk("j.start_lit", PC, 32'h4000_0010);
        step("j.jump", 0, 0, 1, 0, 1, 1, 32'h0, 26'h40);
        chk("j.pc_lit", PC, 32'h4000_0100);
        chk("j.seqerr_lit", 32'(SeqError), 32'h0);
        chk("j.cnt_lit", 32'(TakenCount), 32'h2);

        // PC wrap
        do_reset("r4", 0);
        step("w.load", 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC, 26'h0);
        step("w.br", 0, 0, 1, 1, 0, 0, 32'h0, 26'h0);
        chk("w.top_lit", PC, 32'hFFFF_FFFC);
        step("w.fetch", 1, 0, 0, 0, 0, 0, 32'h0, 26'h0);
        chk("w.wrap_lit", PC, 32'h0);

        // BranchEval while idle is sticky until reset
        step("se.eval", 0, 0, 1, 0, 1, 0, 32'h0, 26'h0);
        chk("se.set_lit", 32'(SeqError), 32'h1);
        chk("se.pc_lit", PC, 32'h0);
        fetch_n(2);
        step("se.load", 0, 1, 0, 0, 0, 0, 32'h8, 26'h0);
        step("se.ok", 0, 0, 1, 0, 1, 0, 32'h0, 26'h0);
        chk("se.sticky_lit", 32'(SeqError), 32'h1);
        do_reset("se.rst", 1);
        chk("se.clr_lit", 32'(SeqError), 32'h0);

        // reset discards a held target
        fetch_n(3);
        step("rt.load", 0, 1, 0, 0, 0, 0, 32'h100, 26'h0);
        do_reset("rt.rst", 0);
        chk("rt.valid_lit", 32'(TargetValid), 32'h0);
        step("rt.eval", 0, 0, 1, 0, 1, 0, 32'h0, 26'h0);
        chk("rt.seqerr_lit", 32'(SeqError), 32'h1);
        chk("rt.pc_lit", PC, 32'h0);

        // counter wrap at TB_CNT_W bits
        do_reset("cw", 0);
        for (int i = 0; i < (1 << TB_CNT_W) + 3; i++)
            step("cw.jump", 0, 0, 0, 0, 0, 1, 32'h0, 26'(i));
        chk("cw.wrap_lit", 32'(TakenCount), 32'h3);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset("rnd.rst", $urandom_range(0, 1) == 1);
            r = $urandom;
            k = 0;
            step("rnd",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0,
                 r << 2,
                 26'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
